skew_align_feeder: RTL and testbench

- Parametrised successor of the single-lane byte sequencer and alignment FIFO pair.
- Accepts one packed vector word per transaction for LANES lanes, each holding K elements of EW bits.
- Writes each lane into its own circular FIFO with a lane-dependent leading zero skew: lane l gets l zero elements, then its K elements, LSB element first.
- Sits between the host load path and a systolic array edge. A shared read enable pops all lanes together, which presents a diagonal wavefront.

---
 rtl/skew_align_pkg.sv | 28 ++
 rtl/skew_lane_fifo.sv | 52 +++++
 rtl/skew_align_feeder.sv | 152 +++++++++++++++
 tb/tb_skew_align_feeder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_align_pkg.sv
// Shared types and constants for the skewed systolic-edge feeder.
// FSM state encoding, step-counter width helper and default parameters.
package skew_align_pkg;

   localparam int LANES_DEF = 4;
   localparam int EW_DEF    = 8;
   localparam int K_DEF     = 4;
   localparam int DEPTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEQ  = 2'd1,
      TAIL = 2'd2
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Step counter must hold 0..LANES-2+K; never narrower than one bit.
   function automatic int step_w(input int lanes, input int k);
      return (clog2(lanes + k) < 1) ? 1 : clog2(lanes + k);
   endfunction

endpackage

// File: rtl/skew_lane_fifo.sv
// One lane of the feeder: first-word-fall-through circular FIFO.
// Head is presented combinationally; an empty lane reads as zero.
module skew_lane_fifo #(
   parameter int EW    = 8,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [EW-1:0] wr_data,
   input  logic          rd_en,
   output logic [EW-1:0] rd_data,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_wr;
   logic          do_rd;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         if (do_wr && !do_rd)
            count <= count + (AW+1)'(1);
         else if (!do_wr && do_rd)
            count <= count - (AW+1)'(1);
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/skew_align_feeder.sv
// Skewed multi-lane feeder for a systolic array edge; lane l gets l leading zeros.
// Optional trailing zero padding to equal lane length: define SKEW_ALIGN_TRAILING_PAD_EN.
//
//  state | meaning
//  IDLE  | ready for a word; captures in_data on in_valid
//  SEQ   | steps 0..LANES-2+K, writes skew zeros then elements into each lane
//  TAIL  | steps 0..LANES-2, pads finished lanes with zeros (feature build only)
module skew_align_feeder
   import skew_align_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int EW    = EW_DEF,
   parameter int K     = K_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*K*EW-1:0] in_data,
   input  logic                  rd_en,
   output logic [LANES*EW-1:0]   out_data,
   output logic                  out_valid,
   output logic [LANES-1:0]      lane_full,
   output logic [LANES-1:0]      lane_empty,
   output logic                  busy
);

   localparam int SW = step_w(LANES, K);
   localparam logic [SW-1:0] SEQ_LAST = SW'(LANES - 2 + K);

   state_t                state;
   state_t                state_nx;
   logic [SW-1:0]         step;
   logic [SW-1:0]         step_nx;
   logic                  capture;
   logic [LANES*K*EW-1:0] word_q;
   logic [LANES-1:0]      sched;
   logic [LANES-1:0]      wr_en_l;
   logic [LANES*EW-1:0]   wr_data_l;
   logic                  commit;
   logic                  pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         step   <= '0;
         word_q <= '0;
      end else begin
         state <= state_nx;
         step  <= step_nx;
         if (capture) word_q <= in_data;
      end
   end

   // Per-lane write schedule for the current step; data defaults to a skew zero.
   always_comb begin
      sched     = '0;
      wr_data_l = '0;
      for (int l = 0; l < LANES; l++) begin
         if (state == SEQ) begin
            if (int'(step) < l) begin
               sched[l] = 1'b1;
            end else if (int'(step) < l + K) begin
               sched[l] = 1'b1;
               wr_data_l[l*EW +: EW] = word_q[l*K*EW + (int'(step) - l)*EW +: EW];
            end
         end
`ifdef SKEW_ALIGN_TRAILING_PAD_EN
         else if (state == TAIL) begin
            if (int'(step) < LANES - 1 - l) sched[l] = 1'b1;
         end
`endif
      end
   end

   // Any scheduled lane being full holds every lane so the diagonal stays intact.
   assign commit  = ~|(sched & lane_full);
   assign wr_en_l = sched & {LANES{commit}};

   always_comb begin
      state_nx = state;
      step_nx  = step;
      in_ready = 1'b0;
      capture  = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = !reset;
            if (in_valid && !reset) begin
               capture  = 1'b1;
               state_nx = SEQ;
               step_nx  = '0;
            end
         end
         SEQ: begin
            if (commit) begin
               if (step == SEQ_LAST) begin
                  step_nx = '0;
`ifdef SKEW_ALIGN_TRAILING_PAD_EN
                  state_nx = TAIL;
`else
                  state_nx = IDLE;
`endif
               end else begin
                  step_nx = step + SW'(1);
               end
            end
         end
         TAIL: begin
            if (commit) begin
               if (step == SW'(LANES - 2)) begin
                  state_nx = IDLE;
                  step_nx  = '0;
               end else begin
                  step_nx = step + SW'(1);
               end
            end
         end
         default: begin
            state_nx = IDLE;
            step_nx  = '0;
         end
      endcase
   end

   assign busy = (state != IDLE);

`ifdef SKEW_ALIGN_TRAILING_PAD_EN
   assign out_valid = &(~lane_empty);
`else
   assign out_valid = |(~lane_empty);
`endif

   assign pop = rd_en && out_valid;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      skew_lane_fifo #(
         .EW    (EW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (wr_en_l[l]),
         .wr_data (wr_data_l[l*EW +: EW]),
         .rd_en   (pop),
         .rd_data (out_data[l*EW +: EW]),
         .full    (lane_full[l]),
         .empty   (lane_empty[l])
      );
   end

endmodule

// File: tb/tb_skew_align_feeder.sv
// Scoreboard bench for skew_align_feeder (LANES=4, EW=8, K=4, DEPTH=8).
// Stimulus pushes expected pop words; a negedge monitor compares on each accepted pop.
module tb_skew_align_feeder;

   localparam int LANES = 4;
   localparam int EW    = 8;
   localparam int K     = 4;
   localparam int DEPTH = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES*K*EW-1:0] in_data;
   logic                  rd_en;
   logic [LANES*EW-1:0]   out_data;
   logic                  out_valid;
   logic [LANES-1:0]      lane_full;
   logic [LANES-1:0]      lane_empty;
   logic                  busy;

   skew_align_feeder #(
      .LANES (LANES),
      .EW    (EW),
      .K     (K),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .rd_en      (rd_en),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .lane_full  (lane_full),
      .lane_empty (lane_empty),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q [$];

   // Reference lane contents: simple append/pop arrays per lane.
   logic [7:0] mq [LANES][64];
   int         mh [LANES];
   int         mt [LANES];

   localparam logic [127:0] W1 = {32'h34333231, 32'h24232221, 32'h14131211, 32'h04030201};
   localparam logic [127:0] W2 = {32'hB4B3B2B1, 32'hA4A3A2A1, 32'h94939291, 32'h84838281};
   localparam logic [127:0] W3 = {32'hF4F3F2F1, 32'hE4E3E2E1, 32'hD4D3D2D1, 32'hC4C3C2C1};
   localparam logic [127:0] W4 = {32'h78777675, 32'h68676665, 32'h58575655, 32'h48474645};
   localparam logic [127:0] W5 = {32'hEEEDECEB, 32'hDEDDDCDB, 32'hCECDCCCB, 32'hBEBDBCBB};
   localparam logic [127:0] W6 = {32'h3C3B3A39, 32'h2C2B2A29, 32'h1C1B1A19, 32'h0C0B0A09};

   // Pops of W1, {lane3,lane2,lane1,lane0}: lane l shows element i-l on pop i.
   logic [31:0] hand [7] = '{32'h00000001, 32'h00001102, 32'h00211203, 32'h31221304,
                             32'h32231400, 32'h33240000, 32'h34000000};

`ifdef SKEW_ALIGN_TRAILING_PAD_EN
   localparam int CNT_L0 = 7, CNT_L1 = 7, CNT_L2 = 7, CNT_L3 = 7;
`else
   localparam int CNT_L0 = 4, CNT_L1 = 5, CNT_L2 = 6, CNT_L3 = 7;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0 && rd_en === 1'b1 && out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: actual %h required none", out_data);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("sb_pop", out_data, e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int l = 0; l < LANES; l++) begin
         mh[l] = 0;
         mt[l] = 0;
      end
   endtask

   task automatic model_append(input logic [127:0] w);
      for (int l = 0; l < LANES; l++) begin
         for (int z = 0; z < l; z++) begin
            mq[l][mt[l]] = 8'h00;
            mt[l]++;
         end
         for (int e = 0; e < K; e++) begin
            mq[l][mt[l]] = w[l*32 + e*8 +: 8];
            mt[l]++;
         end
`ifdef SKEW_ALIGN_TRAILING_PAD_EN
         for (int z = 0; z < LANES - 1 - l; z++) begin
            mq[l][mt[l]] = 8'h00;
            mt[l]++;
         end
`endif
      end
   endtask

   task automatic model_pop(output logic [31:0] e);
      e = '0;
      for (int l = 0; l < LANES; l++) begin
         if (mh[l] < mt[l]) begin
            e[l*8 +: 8] = mq[l][mh[l]];
            mh[l]++;
         end
      end
   endtask

   task automatic model_push();
      logic [31:0] e;
      model_pop(e);
      exp_q.push_back(e);
   endtask

   task automatic send_word(input logic [127:0] w);
      int b;
      b = 0;
      while (!in_ready && b < 50) begin
         tick();
         b++;
      end
      check("send_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
      model_append(w);
   endtask

   task automatic wait_idle();
      int b;
      b = 0;
      while (busy && b < 100) begin
         tick();
         b++;
      end
      check("wait_idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_counts(input string name, input int c0, input int c1,
                               input int c2, input int c3);
      check({name, "_l0"}, 32'(dut.g_lane[0].u_fifo.count), 32'(c0));
      check({name, "_l1"}, 32'(dut.g_lane[1].u_fifo.count), 32'(c1));
      check({name, "_l2"}, 32'(dut.g_lane[2].u_fifo.count), 32'(c2));
      check({name, "_l3"}, 32'(dut.g_lane[3].u_fifo.count), 32'(c3));
   endtask

   // One word, no reads until idle, then seven back-to-back pops.
   task automatic basic_word(input logic [127:0] w, input bit use_hand);
      logic [31:0] e;
      send_word(w);
      wait_idle();
      check_counts("basic_cnt", CNT_L0, CNT_L1, CNT_L2, CNT_L3);
      rd_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (use_hand) begin
            model_pop(e);
            exp_q.push_back(hand[i]);
         end else begin
            model_push();
         end
         if (i == 6) check("ov_before_last_pop", {31'd0, out_valid}, 32'd1);
         tick();
      end
      rd_en = 1'b0;
      check("ov_after_drain", {31'd0, out_valid}, 32'd0);
      check("empty_after_drain", {28'd0, lane_empty}, 32'hF);
   endtask

   initial begin
      int nlow;
      int npop;
      reset    = 1'b1;
      in_valid = 1'b0;
      rd_en    = 1'b0;
      in_data  = '0;
      model_clear();
      #2;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_lane_full", {28'd0, lane_full}, 32'd0);
      check("rst_lane_empty", {28'd0, lane_empty}, 32'hF);
      check("rst_busy", {31'd0, busy}, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("ready_after_release", {31'd0, in_ready}, 32'd1);

      basic_word(W1, 1'b1);

`ifndef SKEW_ALIGN_TRAILING_PAD_EN
      // Back-to-back words with in_valid held.
      in_valid = 1'b1;
      in_data  = W2;
      tick();
      model_append(W2);
      in_data = W3;
      nlow = 0;
      while (!in_ready && nlow < 20) begin
         nlow++;
         tick();
      end
      check("b2b_ready_low", 32'(nlow), 32'd7);
      tick();
      in_valid = 1'b0;
      model_append(W3);

      // Second word stalls once lane 3 fills at step 0.
      repeat (5) tick();
      check("stall_busy", {31'd0, busy}, 32'd1);
      check("stall_full", {28'd0, lane_full}, 32'h8);
      check_counts("stall_cnt", 5, 6, 7, 8);
      model_push();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check_counts("after_pop_cnt", 4, 5, 6, 7);
      check("after_pop_full", {28'd0, lane_full}, 32'h0);
      tick();
      check_counts("resume_cnt", 5, 6, 7, 8);
      check("resume_busy", {31'd0, busy}, 32'd1);

      npop = 0;
      while (out_valid && npop < 40) begin
         model_push();
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
         tick();
         tick();
         npop++;
      end
      check("drain_pops", 32'(npop), 32'd13);
      check("drain_busy", {31'd0, busy}, 32'd0);

      // Reads overlap writes: lane 3 count holds at 1 and its pointers wrap.
      send_word(W4);
      tick();
      rd_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         model_push();
         tick();
         if (i < 6) check("simul_cnt3", 32'(dut.g_lane[3].u_fifo.count), 32'd1);
      end
      rd_en = 1'b0;
      check("simul_empty", {28'd0, lane_empty}, 32'hF);
      check("simul_wr_ptr3", 32'(dut.g_lane[3].u_fifo.wr_ptr), 32'd4);
      check("simul_rd_ptr3", 32'(dut.g_lane[3].u_fifo.rd_ptr), 32'd4);
      wait_idle();

      // Reset while the sequencer sits at step 3.
      send_word(W5);
      tick();
      tick();
      tick();
      check("pre_reset_step", 32'(dut.step), 32'd3);
      reset = 1'b1;
      #1;
      check("midrst_empty", {28'd0, lane_empty}, 32'hF);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out_data", out_data, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      model_clear();
      #1;
      check("midrst_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_data_after", out_data, 32'd0);
      basic_word(W6, 1'b0);
`endif

      tick();
      tick();
      check("sb_leftover", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

endmodule
